// File: rtl/mc_core_ctrl_if.sv
// rtl/mc_core_ctrl_if.sv - control/datapath bus of the multi-cycle RISC-V controller
// master = controller side, slave = datapath/memory side.
interface mc_core_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       alu_zero;
  logic       alu_lt;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_src;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       alu_op_sel;
  logic       reg_write;
  logic [1:0] wb_src;
  logic       illegal;
  logic       instret;
  logic [2:0] state;

  modport master (
    input  opcode, func3, alu_zero, alu_lt, mem_ready,
    output mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op_sel, reg_write, wb_src,
           illegal, instret, state
  );

  modport slave (
    output opcode, func3, alu_zero, alu_lt, mem_ready,
    input  mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op_sel, reg_write, wb_src,
           illegal, instret, state
  );
endinterface

// File: rtl/mc_core_ctrl.sv
// rtl/mc_core_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB control FSM for the multi-cycle core
// Define MC_CTRL_TIMEOUT_EN to add the memory-wait watchdog and TRAP state.
module mc_core_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  mc_core_ctrl_if.master bus
);

  localparam logic [6:0] OP_ARITH = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mc_core_ctrl: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
`ifdef MC_CTRL_TIMEOUT_EN
    , TRAP = 3'd6
`endif
  } state_t;

  // Controls registered on entry to a state; jump/branch qualify pc_write in EXEC.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op_sel;
    logic       reg_write;
    logic [1:0] wb_src;
    logic       instret;
    logic       jump;
    logic       branch;
  } ctl_t;

  state_t     state_q;
  state_t     nxt;
  ctl_t       ctl_q;
  logic       illegal_q;
  logic       supported;
  logic       fetch_go;
  logic       taken;
  logic       pc_write;
  logic       timeout_hit;

  function automatic ctl_t entry_ctl(input state_t s, input logic [6:0] op);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  c.mem_req = 1'b1;
      DECODE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd1;
      end
      EXEC: begin
        case (op)
          OP_ARITH: c.alu_op_sel = 1'b1;
          OP_IMM: begin
            c.alu_src_b  = 2'd1;
            c.alu_op_sel = 1'b1;
          end
          OP_LW, OP_SW: c.alu_src_b = 2'd1;
          OP_BR: begin
            c.alu_op_sel = 1'b1;
            c.branch     = 1'b1;
            c.instret    = 1'b1;
          end
          OP_JAL: begin
            c.jump      = 1'b1;
            c.reg_write = 1'b1;
            c.wb_src    = 2'd2;
            c.instret   = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        c.mem_req      = 1'b1;
        c.mem_addr_src = 1'b1;
        c.mem_we       = (op == OP_SW);
      end
      WB: begin
        c.reg_write = 1'b1;
        c.instret   = 1'b1;
        c.wb_src    = (op == OP_LW) ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign supported = (bus.opcode == OP_ARITH) || (bus.opcode == OP_IMM) ||
                     (bus.opcode == OP_LW)    || (bus.opcode == OP_SW)  ||
                     (bus.opcode == OP_BR)    || (bus.opcode == OP_JAL);

  // The first FETCH cycle after reset has mem_req low, so mem_ready is ignored there.
  assign fetch_go = (state_q == FETCH) && ctl_q.mem_req && bus.mem_ready;

  // BLT uses the LT bit; every other func3 falls back to the BEQ rule.
  assign taken = (bus.func3 == 3'b100) ? bus.alu_lt : bus.alu_zero;

`ifdef MC_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       mem_wait;

  assign mem_wait    = ctl_q.mem_req && !bus.mem_ready;
  assign timeout_hit = mem_wait && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    nxt = state_q;
    case (state_q)
      FETCH:  if (fetch_go) nxt = DECODE;
      DECODE: nxt = supported ? EXEC : HALT;
      EXEC: begin
        case (bus.opcode)
          OP_LW, OP_SW:     nxt = MEM;
          OP_ARITH, OP_IMM: nxt = WB;
          default:          nxt = FETCH;
        endcase
      end
      MEM:    if (bus.mem_ready) nxt = (bus.opcode == OP_SW) ? FETCH : WB;
      WB:     nxt = FETCH;
      default: nxt = state_q;
    endcase
`ifdef MC_CTRL_TIMEOUT_EN
    if (timeout_hit) nxt = TRAP;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ctl_q     <= '0;
      illegal_q <= 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
      wait_cnt  <= 8'd0;
`endif
    end else begin
      state_q <= nxt;
      ctl_q   <= entry_ctl(nxt, bus.opcode);
      if ((state_q == DECODE && !supported) || timeout_hit) illegal_q <= 1'b1;
`ifdef MC_CTRL_TIMEOUT_EN
      if (state_q != nxt)
        wait_cnt <= 8'd0;
      else if (mem_wait)
        wait_cnt <= wait_cnt + 8'd1;
`endif
    end
  end

  assign pc_write = fetch_go || ctl_q.jump || (ctl_q.branch && taken);

  assign bus.mem_req      = ctl_q.mem_req;
  assign bus.mem_we       = ctl_q.mem_we;
  assign bus.mem_addr_src = ctl_q.mem_addr_src;
  assign bus.ir_write     = fetch_go;
  assign bus.pc_write     = pc_write;
  assign bus.pc_src       = fetch_go ? 2'd0 : (pc_write ? 2'd1 : 2'd2);
  assign bus.alu_src_a    = ctl_q.alu_src_a;
  assign bus.alu_src_b    = ctl_q.alu_src_b;
  assign bus.alu_op_sel   = ctl_q.alu_op_sel;
  assign bus.reg_write    = ctl_q.reg_write;
  assign bus.wb_src       = ctl_q.wb_src;
  assign bus.illegal      = illegal_q;
  assign bus.instret      = ctl_q.instret ||
                            ((state_q == MEM) && ctl_q.mem_we && bus.mem_ready);
  assign bus.state        = state_q;

endmodule

// File: tb/tb_mc_core_ctrl.sv
// tb/tb_mc_core_ctrl.sv - scoreboard bench for mc_core_ctrl
// Per-cycle expected outputs are queued with the stimulus and popped at each negedge.
module tb_mc_core_ctrl;

  localparam logic [6:0] OP_ARITH = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op_sel;
    logic       reg_write;
    logic [1:0] wb_src;
    logic       illegal;
    logic       instret;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       rdy;
    logic       z;
    logic       lt;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  mc_core_ctrl_if bus ();

  mc_core_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t stim(input logic r, input logic [6:0] op, input logic [2:0] f3,
                                 input logic rdy, input logic z, input logic lt);
    stim_t s;
    s.rst = r; s.op = op; s.f3 = f3; s.rdy = rdy; s.z = z; s.lt = lt;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst           = s.rst;
    bus.opcode    = s.op;
    bus.func3     = s.f3;
    bus.mem_ready = s.rdy;
    bus.alu_zero  = s.z;
    bus.alu_lt    = s.lt;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.state = bus.state; o.mem_req = bus.mem_req; o.mem_we = bus.mem_we;
    o.mem_addr_src = bus.mem_addr_src; o.ir_write = bus.ir_write; o.pc_write = bus.pc_write;
    o.pc_src = bus.pc_src; o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b;
    o.alu_op_sel = bus.alu_op_sel; o.reg_write = bus.reg_write; o.wb_src = bus.wb_src;
    o.illegal = bus.illegal; o.instret = bus.instret;
    return o;
  endfunction

  // Reference outputs of each state, written straight from the control table.
  function automatic obs_t idle(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state  = st;
    o.pc_src = 2'd2;
    return o;
  endfunction

  function automatic obs_t e_fetch(input logic rdy);
    obs_t o;
    o = idle(3'd0);
    o.mem_req = 1'b1;
    if (rdy) begin
      o.ir_write = 1'b1; o.pc_write = 1'b1; o.pc_src = 2'd0;
    end
    return o;
  endfunction

  function automatic obs_t e_decode();
    obs_t o;
    o = idle(3'd1);
    o.alu_src_a = 1'b1; o.alu_src_b = 2'd1;
    return o;
  endfunction

  function automatic obs_t e_exec(input logic [6:0] op, input logic take);
    obs_t o;
    o = idle(3'd2);
    case (op)
      OP_ARITH: o.alu_op_sel = 1'b1;
      OP_IMM:   begin o.alu_src_b = 2'd1; o.alu_op_sel = 1'b1; end
      OP_LW, OP_SW: o.alu_src_b = 2'd1;
      OP_BR: begin
        o.alu_op_sel = 1'b1; o.instret = 1'b1;
        if (take) begin o.pc_write = 1'b1; o.pc_src = 2'd1; end
      end
      OP_JAL: begin
        o.pc_write = 1'b1; o.pc_src = 2'd1; o.reg_write = 1'b1;
        o.wb_src = 2'd2; o.instret = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t e_mem(input logic sw, input logic rdy);
    obs_t o;
    o = idle(3'd3);
    o.mem_req = 1'b1; o.mem_addr_src = 1'b1; o.mem_we = sw; o.instret = sw & rdy;
    return o;
  endfunction

  function automatic obs_t e_wb(input logic lw);
    obs_t o;
    o = idle(3'd4);
    o.reg_write = 1'b1; o.instret = 1'b1; o.wb_src = lw ? 2'd1 : 2'd0;
    return o;
  endfunction

  function automatic obs_t e_stop(input logic [2:0] st);
    obs_t o;
    o = idle(st);
    o.illegal = 1'b1;
    return o;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    stim_t sq[9];
    obs_t  eq[9];
    obs_t  got, want;
    do_reset();
    sq = '{stim(0, OP_SW, 3'd2, 1, 0, 0), stim(0, OP_SW, 3'd2, 1, 0, 0),
           stim(0, OP_SW, 3'd2, 0, 0, 0), stim(0, OP_SW, 3'd2, 0, 0, 0),
           stim(0, OP_SW, 3'd2, 0, 0, 0), stim(1, OP_SW, 3'd2, 0, 0, 0),
           stim(1, OP_SW, 3'd2, 1, 0, 0), stim(0, OP_SW, 3'd2, 0, 0, 0),
           stim(0, OP_SW, 3'd2, 0, 0, 0)};
    eq = '{idle(3'd0), e_fetch(1), e_decode(), e_exec(OP_SW, 0), e_mem(1, 0),
           e_mem(1, 0), idle(3'd0), idle(3'd0), e_fetch(0)};
    foreach (eq[i]) exp_q.push_back(eq[i]);
    for (int i = 0; i < 9; i++) begin
      drive(sq[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset c%0d: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    stim_t sq[6];
    obs_t  eq[6];
    obs_t  got, want;
    do_reset();
    for (int i = 0; i < 6; i++) sq[i] = stim(0, OP_ARITH, 3'd0, (i != 0 && i != 5), 0, 0);
    eq = '{idle(3'd0), e_fetch(1), e_decode(), e_exec(OP_ARITH, 0), e_wb(0), e_fetch(0)};
    foreach (eq[i]) exp_q.push_back(eq[i]);
    for (int i = 0; i < 6; i++) begin
      drive(sq[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL add c%0d: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    stim_t sq[10];
    obs_t  eq[10];
    obs_t  got, want;
    logic  rdy_pat[10];
    do_reset();
    rdy_pat = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 10; i++) sq[i] = stim(0, OP_LW, 3'd2, rdy_pat[i], 0, 0);
    eq = '{idle(3'd0), e_fetch(1), e_decode(), e_exec(OP_LW, 0), e_mem(0, 0),
           e_mem(0, 0), e_mem(0, 0), e_mem(0, 1), e_wb(1), e_fetch(0)};
    foreach (eq[i]) exp_q.push_back(eq[i]);
    for (int i = 0; i < 10; i++) begin
      drive(sq[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL lw_wait c%0d: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    // Cases: blt lt=1 taken, beq z=0 not taken, blt lt=0 z=1 not taken, bne z=1 (BEQ rule) taken.
    logic [2:0] f3s[4];
    logic       zs[4];
    logic       lts[4];
    logic       takes[4];
    obs_t       got, want;
    do_reset();
    f3s = '{3'b100, 3'b000, 3'b100, 3'b001};
    zs  = '{0, 0, 1, 1};
    lts = '{1, 1, 0, 0};
    takes = '{1, 0, 0, 1};
    exp_q.push_back(idle(3'd0));
    drive(stim(0, OP_BR, 3'd0, 0, 0, 0));
    @(negedge clk);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL branch idle: got %h expected %h", got, want);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(e_fetch(1));
      exp_q.push_back(e_decode());
      exp_q.push_back(e_exec(OP_BR, takes[k]));
      for (int c = 0; c < 3; c++) begin
        drive(stim(0, OP_BR, f3s[k], (c == 0), zs[k], lts[k]));
        @(negedge clk);
        got  = sample();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL branch k%0d c%0d: got %h expected %h", k, c, got, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    stim_t sq[26];
    obs_t  eq[26];
    obs_t  got, want;
    do_reset();
    sq[0] = stim(0, OP_SYS, 3'd0, 0, 0, 0); eq[0] = idle(3'd0);
    sq[1] = stim(0, OP_SYS, 3'd0, 1, 0, 0); eq[1] = e_fetch(1);
    sq[2] = stim(0, OP_SYS, 3'd0, 0, 0, 0); eq[2] = e_decode();
    for (int i = 3; i < 23; i++) begin
      sq[i] = stim(0, OP_SYS, 3'd0, 1'($urandom_range(0, 1)), 0, 0);
      eq[i] = e_stop(3'd5);
    end
    sq[23] = stim(1, OP_SYS, 3'd0, 1, 0, 0); eq[23] = e_stop(3'd5);
    sq[24] = stim(1, OP_SYS, 3'd0, 0, 0, 0); eq[24] = idle(3'd0);
    sq[25] = stim(0, OP_SYS, 3'd0, 0, 0, 0); eq[25] = idle(3'd0);
    foreach (eq[i]) exp_q.push_back(eq[i]);
    for (int i = 0; i < 26; i++) begin
      drive(sq[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL illegal c%0d: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    // addi, jal after one fetch wait, sw, lw; memory otherwise answers at once.
    stim_t sq[19];
    obs_t  eq[19];
    obs_t  got, want;
    do_reset();
    sq = '{stim(0, OP_IMM, 3'd0, 0, 0, 0),
           stim(0, OP_IMM, 3'd0, 1, 0, 0), stim(0, OP_IMM, 3'd0, 1, 0, 0),
           stim(0, OP_IMM, 3'd0, 1, 0, 0), stim(0, OP_IMM, 3'd0, 1, 0, 0),
           stim(0, OP_JAL, 3'd0, 0, 0, 0), stim(0, OP_JAL, 3'd0, 1, 0, 0),
           stim(0, OP_JAL, 3'd0, 1, 0, 0), stim(0, OP_JAL, 3'd0, 1, 0, 0),
           stim(0, OP_SW, 3'd2, 1, 0, 0),  stim(0, OP_SW, 3'd2, 1, 0, 0),
           stim(0, OP_SW, 3'd2, 1, 0, 0),  stim(0, OP_SW, 3'd2, 1, 0, 0),
           stim(0, OP_LW, 3'd2, 1, 0, 0),  stim(0, OP_LW, 3'd2, 1, 0, 0),
           stim(0, OP_LW, 3'd2, 1, 0, 0),  stim(0, OP_LW, 3'd2, 1, 0, 0),
           stim(0, OP_LW, 3'd2, 1, 0, 0),  stim(0, OP_LW, 3'd2, 0, 0, 0)};
    eq = '{idle(3'd0),
           e_fetch(1), e_decode(), e_exec(OP_IMM, 0), e_wb(0),
           e_fetch(0), e_fetch(1), e_decode(), e_exec(OP_JAL, 0),
           e_fetch(1), e_decode(), e_exec(OP_SW, 0), e_mem(1, 1),
           e_fetch(1), e_decode(), e_exec(OP_LW, 0), e_mem(0, 1), e_wb(1),
           e_fetch(0)};
    foreach (eq[i]) exp_q.push_back(eq[i]);
    for (int i = 0; i < 19; i++) begin
      drive(sq[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back c%0d: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef MC_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    obs_t got, want;
    // Four unanswered fetch cycles reach the limit of 4, then TRAP holds.
    do_reset();
    exp_q.push_back(idle(3'd0));
    for (int i = 0; i < 4; i++) exp_q.push_back(e_fetch(0));
    for (int i = 0; i < 3; i++) exp_q.push_back(e_stop(3'd6));
    for (int i = 0; i < 8; i++) begin
      drive(stim(0, OP_ARITH, 3'd0, (i >= 5), 0, 0));
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout_trap c%0d: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    // mem_ready in the limit cycle wins.
    do_reset();
    exp_q.push_back(idle(3'd0));
    for (int i = 0; i < 3; i++) exp_q.push_back(e_fetch(0));
    exp_q.push_back(e_fetch(1));
    exp_q.push_back(e_decode());
    for (int i = 0; i < 6; i++) begin
      drive(stim(0, OP_ARITH, 3'd0, (i == 4), 0, 0));
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout_ready c%0d: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    drive(stim(1, 7'd0, 3'd0, 0, 0, 0));
    test_reset();
    test_alu();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_back_to_back();
`ifdef MC_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_core_ctrl.md
Name: mc_core_ctrl

Overview:
Multi-cycle control FSM for the multi-cycle variant of the RISC-V core. It sequences one shared ALU, the instruction register, the PC and a single-port memory through FETCH, DECODE, EXEC, MEM and WB. It supports addi, add/sub/sll/srl/and/or/xor, beq, blt, jal, lw and sw. It drives datapath selects and enables; the combinational ALU-op decoder stays in the datapath and is gated by alu_op_sel.

Parameters:
TIMEOUT_CYCLES, 255, memory wait limit in cycles; used only with MC_CTRL_TIMEOUT_EN; legal range 1..255.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
opcode  in  7  IR[6:0], valid from DECODE onward
func3  in  3  IR[14:12]
alu_zero  in  1  ALU result == 0
alu_lt  in  1  ALU LT result bit 0
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  store when 1, load/fetch when 0
mem_addr_src  out  1  0 = PC, 1 = ALU result register
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  2  0 = PC+4, 1 = branch/jal target (PC+imm), 2 = hold
alu_src_a  out  1  0 = rs1, 1 = PC
alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
alu_op_sel  out  1  0 = force ADD, 1 = use decoded ALU op
reg_write  out  1  register file write enable
wb_src  out  2  0 = ALU result, 1 = memory data, 2 = PC+4
illegal  out  1  sticky, set by an unsupported opcode
instret  out  1  one-cycle pulse per retired instruction
state  out  3  current FSM state for debug

Behaviour:
- Reset: state = FETCH; illegal = 0. Every output not listed as active in a state is 0; pc_src = 2 when pc_write = 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6 (TRAP only with the optional feature).
- FETCH:
  - Outputs: mem_req = 1, mem_addr_src = 0, mem_we = 0.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
  - Otherwise stay in FETCH with mem_req held.
- DECODE:
  - Outputs: alu_src_a = 1, alu_src_b = 1, alu_op_sel = 0. This precomputes PC+imm into the ALU result register. The PC used is the old PC; the datapath keeps a copy.
  - Supported opcode: go to EXEC.
  - Unsupported opcode: set illegal and go to HALT.
- EXEC, by opcode:
  - ARITH: alu_src_a = 0, alu_src_b = 0, alu_op_sel = 1; go to WB.
  - IMME_ARITH: as ARITH but alu_src_b = 1; go to WB.
  - LW / SW: alu_src_b = 1, alu_op_sel = 0; go to MEM.
  - COND_JMP: alu_src_b = 0, alu_op_sel = 1.
    - Taken when (func3 = 000 and alu_zero) or (func3 = 100 and alu_lt); any other func3 uses the BEQ rule.
    - Taken: pc_write = 1, pc_src = 1. Not taken: PC already holds PC+4.
    - instret = 1; go to FETCH.
  - JAL: pc_write = 1, pc_src = 1, reg_write = 1, wb_src = 2, instret = 1; go to FETCH.
- MEM:
  - Outputs: mem_req = 1, mem_addr_src = 1, mem_we = 1 for SW.
  - SW: on mem_ready, instret = 1 and go to FETCH.
  - LW: on mem_ready, go to WB.
- WB:
  - Outputs: reg_write = 1, instret = 1; go to FETCH.
  - wb_src = 1 for LW, otherwise 0.
- HALT: all enables 0, no exit except rst.
- mem_req is never deasserted before mem_ready in FETCH/MEM. mem_ready while mem_req = 0 is ignored.
- Latency in cycles with mem_ready immediate:
  - ALU ops 4; branch/jal 3; sw 4; lw 5.
  - Each memory wait cycle adds 1.
- rst mid-instruction: next cycle is FETCH with all enables 0 and no partial write. illegal clears.

Optional Feature:
MC_CTRL_TIMEOUT_EN:
- Defined:
  - An 8-bit wait counter clears on entry to FETCH/MEM and increments each cycle mem_req = 1 and mem_ready = 0.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready: go to TRAP, drop mem_req, and set illegal.
  - TRAP behaves like HALT.
  - mem_ready in the same cycle the limit is reached wins; no trap.
- Undefined: no counter and no TRAP state; waits are unbounded.

Test Plan:
- Test 1: rst held 2 cycles mid-MEM of a sw -> next cycle state = 0, mem_req = 0, mem_we = 0, illegal = 0.
- Test 2: add (opcode 0110011), mem_ready always 1 -> states 0,1,2,4,0; reg_write = 1 and instret = 1 only in the WB cycle; alu_op_sel = 1 in EXEC.
- Test 3: lw with mem_ready low 3 cycles in MEM -> mem_req and mem_addr_src = 1 held 4 cycles; WB follows with wb_src = 1; total 8 cycles.
- Test 4: blt with alu_lt = 1, then beq with alu_zero = 0 -> first case: pc_write = 1, pc_src = 1 in EXEC; second case: pc_write = 0 in EXEC; each retires in 3 cycles.
- Test 5: opcode 1110011 -> illegal = 1 after DECODE, state = 5 and stays; mem_req stays 0 for 20 cycles.
- Test 6 (MC_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES = 4): fetch with mem_ready = 0 -> state = 6 after the limit is reached, mem_req = 0. Repeating with mem_ready = 1 in the limit cycle -> DECODE, no trap.
